// File: rtl/fft_post_pkg.sv
// rtl/fft_post_pkg.sv - shared constants, magnitude width and FSM states for the FFT post-processor
// Optional macro FFT_MAG_EXACT_SQ_EN widens the magnitude to re^2+im^2.
package fft_post_pkg;

  localparam int N_PT = 32;
  localparam int DW   = 17;
  localparam int BW   = 5;

`ifdef FFT_MAG_EXACT_SQ_EN
  localparam int MAG_W = 2 * DW - 1;
`else
  localparam int MAG_W = DW;
`endif

  typedef enum logic {S_RE, S_IM} state_t;

  // |x| with the most negative code saturated to the largest positive magnitude
  function automatic logic [DW-2:0] sat_abs(input logic [DW-1:0] x);
    if (x[DW-1] && (x[DW-2:0] == '0)) begin
      return '1;
    end
    return x[DW-1] ? (~x[DW-2:0] + (DW-1)'(1)) : x[DW-2:0];
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// rtl/fft_mag_approx.sv - two-stage magnitude pipeline (abs/max/min/sum)
// FFT_MAG_EXACT_SQ_EN: stage 1 squares, stage 2 sums, instead of max + min/2.
module fft_mag_approx
  import fft_post_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [BW-1:0]    in_bin,
  input  logic [DW-1:0]    re,
  input  logic [DW-1:0]    im,
  output logic             out_valid,
  output logic [BW-1:0]    out_bin,
  output logic [MAG_W-1:0] mag
);

  logic            s1_valid;
  logic [BW-1:0]   s1_bin;
  logic [DW-2:0]   a_abs, b_abs;

  assign a_abs = sat_abs(re);
  assign b_abs = sat_abs(im);

`ifdef FFT_MAG_EXACT_SQ_EN
  logic [2*DW-3:0] sa_q, sb_q;

  // Stage 1: square both saturated magnitudes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q <= '0;
      sb_q <= '0;
    end else begin
      sa_q <= (2*DW-2)'(a_abs) * (2*DW-2)'(a_abs);
      sb_q <= (2*DW-2)'(b_abs) * (2*DW-2)'(b_abs);
    end
  end

  // Stage 2: sum of squares
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
    end else begin
      mag <= {1'b0, sa_q} + {1'b0, sb_q};
    end
  end
`else
  logic [DW-2:0] a_q, b_q, mx, mn;

  // Stage 1: register both absolute values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_abs;
      b_q <= b_abs;
    end
  end

  // Order the pair so the larger carries full weight
  always_comb begin
    mx = (a_q > b_q) ? a_q : b_q;
    mn = (a_q > b_q) ? b_q : a_q;
  end

  // Stage 2: max + min/2, one spare bit absorbs the carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
    end else begin
      mag <= {1'b0, mx} + {2'b00, mn[DW-2:1]};
    end
  end
`endif

  // Bin and valid travel alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_bin    <= in_bin;
      out_valid <= s1_valid;
      out_bin   <= s1_bin;
    end
  end

endmodule

// File: rtl/fft_mag_peak.sv
// rtl/fft_mag_peak.sv - per-bin magnitude and frame peak finder behind the 32-point FFT core
// Optional macro FFT_MAG_EXACT_SQ_EN selects exact squared magnitude.
module fft_mag_peak
  import fft_post_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             finish_i,
  input  logic [DW-1:0]    answer_i,
  output logic             mag_valid_o,
  output logic [BW-1:0]    bin_o,
  output logic [MAG_W-1:0] mag_o,
  output logic             peak_valid_o,
  output logic [BW-1:0]    peak_bin_o,
  output logic [MAG_W-1:0] peak_mag_o,
  output logic             busy_o
);

  state_t             state, state_nx;
  logic [BW:0]        count;
  logic [DW-1:0]      re_buf [N_PT];
  logic               p_valid;
  logic [BW-1:0]      p_bin;
  logic [DW-1:0]      p_re, p_im;
  logic               take;
  logic [MAG_W-1:0]   run_max, max_nx;
  logic [BW-1:0]      run_bin, bin_nx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RE;
    else        state <= state_nx;
  end

  // Flip between real and imaginary halves on the last word of each half
  always_comb begin
    state_nx = state;
    if (finish_i && (&count[BW-1:0])) begin
      state_nx = (state == S_RE) ? S_IM : S_RE;
    end
  end

  // Word counter, holds through gaps and wraps at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count <= '0;
    else if (finish_i) count <= count + (BW+1)'(1);
  end

  assign busy_o = (count != '0);

  // Real-part buffer; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (finish_i && (state == S_RE)) re_buf[count[BW-1:0]] <= answer_i;
  end

  // Pair each imaginary word with its stored real part
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_bin   <= '0;
      p_re    <= '0;
      p_im    <= '0;
    end else begin
      p_valid <= finish_i && (state == S_IM);
      if (finish_i && (state == S_IM)) begin
        p_re  <= re_buf[count[BW-1:0]];
        p_im  <= answer_i;
        p_bin <= count[BW-1:0];
      end
    end
  end

  fft_mag_approx u_mag (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (p_valid),
    .in_bin    (p_bin),
    .re        (p_re),
    .im        (p_im),
    .out_valid (mag_valid_o),
    .out_bin   (bin_o),
    .mag       (mag_o)
  );

  // Running maximum candidate: bin 0 restarts, otherwise strictly greater wins
  always_comb begin
    take   = (bin_o == '0) || (mag_o > run_max);
    max_nx = take ? mag_o : run_max;
    bin_nx = take ? bin_o : run_bin;
  end

  // Peak tracking and end-of-frame report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max      <= '0;
      run_bin      <= '0;
      peak_valid_o <= 1'b0;
      peak_bin_o   <= '0;
      peak_mag_o   <= '0;
    end else begin
      peak_valid_o <= mag_valid_o && (&bin_o);
      if (mag_valid_o) begin
        run_max <= max_nx;
        run_bin <= bin_nx;
        if (&bin_o) begin
          peak_bin_o <= bin_nx;
          peak_mag_o <= max_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_mag_peak.sv
// tb/tb_fft_mag_peak.sv - randomized self-checking bench for fft_mag_peak
module tb_fft_mag_peak;
  import fft_post_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             finish_i;
  logic [DW-1:0]    answer_i;
  logic             mag_valid_o;
  logic [BW-1:0]    bin_o;
  logic [MAG_W-1:0] mag_o;
  logic             peak_valid_o;
  logic [BW-1:0]    peak_bin_o;
  logic [MAG_W-1:0] peak_mag_o;
  logic             busy_o;

`ifdef FFT_MAG_EXACT_SQ_EN
  localparam longint L_BIG = 64'd8589672450;
  localparam longint L_345 = 25;
  localparam longint L_IMP = 65536;
  localparam longint L_TIE = 1000000;
`else
  localparam longint L_BIG = 98302;
  localparam longint L_345 = 5;
  localparam longint L_IMP = 256;
  localparam longint L_TIE = 1000;
`endif

  typedef struct {
    longint t;
    longint bin;
    longint mag;
    longint lb;
    longint lm;
  } exp_t;

  exp_t   mq[$];
  exp_t   pq[$];
  longint cyc = 0;
  int     w = 0;
  longint m_re[N_PT];
  longint m_mag[N_PT];
  longint fr_re[N_PT];
  longint fr_im[N_PT];
  longint fr_lit[N_PT];
  longint pk_lb = -1;
  longint pk_lm = -1;
  longint held_bin = 0;
  longint held_mag = 0;
  int     vectors = 0;
  int     miscompares = 0;
  bit     done_req = 0;
  bit     done_ack = 0;

  fft_mag_peak dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .finish_i     (finish_i),
    .answer_i     (answer_i),
    .mag_valid_o  (mag_valid_o),
    .bin_o        (bin_o),
    .mag_o        (mag_o),
    .peak_valid_o (peak_valid_o),
    .peak_bin_o   (peak_bin_o),
    .peak_mag_o   (peak_mag_o),
    .busy_o       (busy_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint model_mag(input longint re, input longint im);
    longint a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 65535) a = 65535;
    if (b > 65535) b = 65535;
`ifdef FFT_MAG_EXACT_SQ_EN
    return a * a + b * b;
`else
    return (a >= b) ? a + b / 2 : b + a / 2;
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Record what one accepted word must eventually produce
  task automatic accept(input longint v, input longint lit);
    longint acc, b, m, pb, pm;
    acc = cyc + 1;
    if (w < N_PT) begin
      m_re[w] = v;
    end else begin
      b = w - N_PT;
      m = model_mag(m_re[b], v);
      m_mag[b] = m;
      mq.push_back('{acc + 2, b, m, -1, lit});
      if (b == N_PT - 1) begin
        pb = 0;
        pm = m_mag[0];
        for (int i = 1; i < N_PT; i++) begin
          if (m_mag[i] > pm) begin
            pb = i;
            pm = m_mag[i];
          end
        end
        pq.push_back('{acc + 3, pb, pm, pk_lb, pk_lm});
      end
    end
    w = (w + 1) % (2 * N_PT);
  endtask

  task automatic put_word(input longint v, input longint lit);
    logic [63:0] vv;
    @(negedge clk);
    #1;
    vv = v;
    finish_i = 1'b1;
    answer_i = vv[DW-1:0];
    accept(v, lit);
  endtask

  task automatic gap();
    logic [31:0] r;
    @(negedge clk);
    #1;
    r = $urandom;
    finish_i = 1'b0;
    answer_i = r[DW-1:0];
  endtask

  // mode 0: contiguous, 1: gap after every word, 2: random gaps
  task automatic send_frame(input int nwords, input int mode);
    for (int i = 0; i < nwords; i++) begin
      if (i < N_PT) put_word(fr_re[i], -1);
      else          put_word(fr_im[i - N_PT], fr_lit[i - N_PT]);
      if (mode == 1 || (mode == 2 && $urandom_range(2) == 0)) gap();
    end
  endtask

  function automatic longint rnd_word();
    int s;
    s = $urandom_range(7);
    if (s == 0) return -65536;
    if (s == 1) return 65535;
    return longint'($urandom_range(131071)) - 65536;
  endfunction

  task automatic clear_frame(input longint re_v);
    for (int i = 0; i < N_PT; i++) begin
      fr_re[i]  = re_v;
      fr_im[i]  = 0;
      fr_lit[i] = -1;
    end
  endtask

  // Single checker: compares every output every cycle against the model queues
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_bin = 0;
      held_mag = 0;
      chk("rst_mag_valid", longint'(mag_valid_o), 0);
      chk("rst_bin", longint'(bin_o), 0);
      chk("rst_mag", longint'(mag_o), 0);
      chk("rst_peak_valid", longint'(peak_valid_o), 0);
      chk("rst_peak_bin", longint'(peak_bin_o), 0);
      chk("rst_peak_mag", longint'(peak_mag_o), 0);
      chk("rst_busy", longint'(busy_o), 0);
    end else begin
      if (mq.size() != 0 && mq[0].t == cyc) begin
        e = mq.pop_front();
        chk("mag_valid", longint'(mag_valid_o), 1);
        chk("bin", longint'(bin_o), e.bin);
        chk("mag", longint'(mag_o), e.mag);
        if (e.lm >= 0) chk("mag_literal", longint'(mag_o), e.lm);
      end else begin
        chk("mag_idle", longint'(mag_valid_o), 0);
      end
      if (pq.size() != 0 && pq[0].t == cyc) begin
        e = pq.pop_front();
        chk("peak_valid", longint'(peak_valid_o), 1);
        held_bin = e.bin;
        held_mag = e.mag;
        if (e.lb >= 0) chk("peak_bin_literal", longint'(peak_bin_o), e.lb);
        if (e.lm >= 0) chk("peak_mag_literal", longint'(peak_mag_o), e.lm);
      end else begin
        chk("peak_idle", longint'(peak_valid_o), 0);
      end
      chk("peak_bin_hold", longint'(peak_bin_o), held_bin);
      chk("peak_mag_hold", longint'(peak_mag_o), held_mag);
      chk("busy", longint'(busy_o), (w != 0) ? 1 : 0);
    end
    if (done_req && !done_ack) begin
      chk("mag_queue_drained", longint'(mq.size()), 0);
      chk("peak_queue_drained", longint'(pq.size()), 0);
      done_ack = 1;
    end
  end

  initial begin
    rst_n    = 1'b0;
    finish_i = 1'b0;
    answer_i = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    gap();

    // Impulse, contiguous
    clear_frame(256);
    for (int i = 0; i < N_PT; i++) fr_lit[i] = L_IMP;
    pk_lb = 0; pk_lm = L_IMP;
    send_frame(2 * N_PT, 0);
    repeat (4) gap();

    // Magnitude corners
    clear_frame(0);
    fr_re[0] = -65536; fr_im[0] = -65536; fr_lit[0] = L_BIG;
    fr_re[1] = 3;      fr_im[1] = -4;     fr_lit[1] = L_345;
    fr_re[2] = 0;      fr_im[2] = 1;      fr_lit[2] = 1;
    fr_lit[3] = 0;
    pk_lb = 0; pk_lm = L_BIG;
    send_frame(2 * N_PT, 0);
    repeat (4) gap();

    // Impulse with a gap after every word
    clear_frame(256);
    for (int i = 0; i < N_PT; i++) fr_lit[i] = L_IMP;
    pk_lb = 0; pk_lm = L_IMP;
    send_frame(2 * N_PT, 1);
    repeat (4) gap();

    // Tie between bins 5 and 20 keeps the lower bin
    clear_frame(10);
    fr_re[5] = 1000; fr_re[20] = 1000;
    pk_lb = 5; pk_lm = L_TIE;
    send_frame(2 * N_PT, 0);

    // Back-to-back frames, peaks at 31 then 7
    for (int i = 0; i < N_PT; i++) begin
      fr_re[i] = i * 3; fr_im[i] = -i; fr_lit[i] = -1;
    end
    pk_lb = 31; pk_lm = -1;
    send_frame(2 * N_PT, 0);
    clear_frame(10);
    fr_re[7] = -3000; fr_im[7] = 2000;
    pk_lb = 7; pk_lm = -1;
    send_frame(2 * N_PT, 0);
    repeat (4) gap();

    // Mid-frame reset after 40 words, then a fresh frame
    for (int i = 0; i < N_PT; i++) begin
      fr_re[i] = rnd_word(); fr_im[i] = rnd_word(); fr_lit[i] = -1;
    end
    pk_lb = -1; pk_lm = -1;
    send_frame(40, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    finish_i = 1'b0;
    mq.delete();
    pq.delete();
    w = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    clear_frame(256);
    for (int i = 0; i < N_PT; i++) fr_lit[i] = L_IMP;
    pk_lb = 0; pk_lm = L_IMP;
    send_frame(2 * N_PT, 0);

    // Random frames with random gaps
    pk_lb = -1; pk_lm = -1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N_PT; i++) begin
        fr_re[i] = rnd_word(); fr_im[i] = rnd_word(); fr_lit[i] = -1;
      end
      send_frame(2 * N_PT, (f % 2 == 0) ? 2 : 0);
    end

    repeat (8) gap();
    done_req = 1;
    repeat (3) gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_mag_peak.md
Name: fft_mag_peak

Overview:
- Sits directly downstream of the 32-point FFT core.
- Consumes the core's serial output stream: 64 words per frame, 32 real parts (bins 0..31) followed by 32 imaginary parts (bins 0..31), qualified by the core's finish strobe.
- Buffers the real parts and pairs each arriving imaginary part with its stored real part.
- Emits a per-bin magnitude estimate (alpha-max-plus-beta-min, alpha=1, beta=1/2) with its bin index, then reports the frame's peak bin.

Parameters:
- N_PT, 32, FFT points per frame; must be a power of two.
- DW, 17, input word width (two's complement), matching the core's answer port.
- BW, 5, bin index width, log2(N_PT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- finish_i  in  1  input word valid, driven by the FFT core's finish.
- answer_i  in  DW  signed input word (real or imag), driven by the FFT core's answer.
- mag_valid_o  out  1  mag_o/bin_o valid this cycle.
- bin_o  out  BW  bin index of mag_o.
- mag_o  out  DW  unsigned magnitude estimate.
- peak_valid_o  out  1  one-cycle pulse, peak result valid.
- peak_bin_o  out  BW  bin with the largest mag_o in the frame.
- peak_mag_o  out  DW  that magnitude.
- busy_o  out  1  high while a frame is partially received.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; FSM is in S_RE; word counter is 0; peak registers are 0.
  - The real-part buffer is not cleared.
  - Reset mid-frame discards the partial frame; no output pulses follow.
- Input acceptance:
  - A word is accepted on every rising edge with finish_i=1. There is no backpressure.
  - Gaps (finish_i=0) are allowed anywhere; the counter holds during a gap.
- Word counter: 6 bits, increments per accepted word, wraps 63->0.
- FSM:
  - S_RE, count 0..31: store answer_i at buffer[count[4:0]]. On the 32nd accepted word -> S_IM.
  - S_IM, count 32..63: read buffer[count[4:0]] as re, take answer_i as im, push both into the magnitude pipe. On the 64th accepted word -> S_RE.
- Back-to-back frames: word 0 of the next frame may arrive the cycle after word 63 with no gap.
- busy_o = (count != 0).
- Magnitude pipe (2 stages), for an imag word accepted at edge t:
  - Stage 1 registers a=|re| and b=|im|. Absolute values saturate: -65536 -> 65535. Stage 1 also registers the bin.
  - Stage 2 registers mag = max(a,b) + (min(a,b)>>1), truncating, unsigned. The maximum is 98302, which fits in 17 bits, so there is no overflow.
  - mag_valid_o=1 with mag_o and bin_o at the edge t+2, i.e. valid for the cycle after that edge.
  - mag_valid_o is 0 otherwise.
- Peak tracking:
  - On each mag_valid_o, compare mag_o against the running maximum. Update only on strictly greater, so ties keep the lowest bin.
  - The running maximum is reset to 0 by bin 0's entry: bin 0 always loads.
  - When bin 31 is output, peak_valid_o pulses one cycle later, with peak_bin_o and peak_mag_o holding until the next pulse.
  - An all-zero frame reports peak_bin_o=0, peak_mag_o=0.

Optional Feature:
- Macro: FFT_MAG_EXACT_SQ_EN.
- Defined: mag_o carries re^2+im^2 instead of the approximation.
  - mag_o width becomes 2*DW-1 (33 bits); peak_mag_o widens equally.
  - Stage 1 computes the two squares; stage 2 computes the sum.
  - Latency stays at 2 cycles; peak rules are unchanged.
- Undefined: alpha-max-plus-beta-min as above.

Decomposition:
- Package fft_post_pkg holds:
  - N_PT, DW, BW constants.
  - Magnitude width constant MAG_W, selected by FFT_MAG_EXACT_SQ_EN.
  - FSM state enum (S_RE, S_IM).
- One sub-module, fft_mag_approx: the 2-stage abs/max/min/sum pipeline. It takes re, im, bin and valid in, and gives mag, bin and valid out.
- Buffer, FSM and peak logic live in the top.

Test Plan:
- Impulse response: re[k]=256, im[k]=0 for all k, contiguous 64 words. Expect:
  - 32 mag_valid_o pulses with mag_o=256 and bin_o 0..31.
  - peak_bin_o=0, peak_mag_o=256, with peak_valid_o exactly 1 cycle after bin 31.
- Magnitude corners:
  - re=-65536, im=-65536 -> mag_o=98302.
  - re=3, im=-4 -> mag_o=5.
  - re=0, im=1 -> mag_o=1.
  - With FFT_MAG_EXACT_SQ_EN, re=3, im=-4 -> mag_o=25.
- Gapped input: finish_i toggles 1/0 every cycle across a frame. Expect the same bins and values as the contiguous run, each mag_o 2 cycles after its imag word, and busy_o high from word 0 to word 63.
- Peak tie: bins 5 and 20 both give mag 1000 and all others give 10. Expect peak_bin_o=5, peak_mag_o=1000.
- Back-to-back frames: frame A has its peak at bin 31, frame B has its peak at bin 7, with no gap between frames. Expect two peak pulses 64 cycles apart reporting 31 then 7, with no bin mixing.
- Mid-frame reset: assert rst_n=0 after 40 words, then send a full new frame. Expect:
  - All outputs 0 during reset.
  - No stale pulses.
  - The new frame is processed from word 0 correctly.
